// File: rtl/spi_master_controller.sv
// spi_master_controller: SPI master engine, one valid/ready word per chip-select frame
module spi_master_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV = 2,
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0,
   parameter bit MSB_FIRST = 1'b1,
   parameter int C2T_DELAY = 1,
   parameter int T2C_DELAY = 1
) (
   input  logic                  pclk,
   input  logic                  areset,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sclk,
   output logic                  cs,
   output logic                  mosi,
   input  logic                  miso
);
   typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;
   state_t state, state_nxt;
   logic [15:0] cnt;
   logic [6:0] ecnt;
   logic [DATA_WIDTH-1:0] tx_sh, rx_sh, tx_nxt;
   logic accept, tog, lead, trail, last_edge, term, sample, shift, done;
   logic data_first, sh_first, nxt_first;
   always_comb begin
      accept = state == IDLE && tx_valid && tx_ready;
      tog = state == TRANSFER && cnt == 16'(CLK_DIV - 1);
      lead = tog && !ecnt[0];
      trail = tog && ecnt[0];
      last_edge = tog && ecnt == 7'(2 * DATA_WIDTH - 1);
      term = state == SETUP ? cnt == 16'(C2T_DELAY - 1) :
             state == HOLD  ? cnt == 16'(T2C_DELAY - 1) : tog;
      sample = CPHA ? trail : lead;
      shift = CPHA ? lead : (trail && !last_edge);
      done = state == HOLD && term;
      tx_nxt = MSB_FIRST ? tx_sh << 1 : tx_sh >> 1;
      data_first = MSB_FIRST ? tx_data[DATA_WIDTH-1] : tx_data[0];
      sh_first = MSB_FIRST ? tx_sh[DATA_WIDTH-1] : tx_sh[0];
      nxt_first = MSB_FIRST ? tx_nxt[DATA_WIDTH-1] : tx_nxt[0];
      state_nxt = state == IDLE     ? (accept ? SETUP : IDLE) :
                  state == SETUP    ? (term ? TRANSFER : SETUP) :
                  state == TRANSFER ? (last_edge ? HOLD : TRANSFER) :
                                      (term ? IDLE : HOLD);
   end
   always_ff @(posedge pclk)
      if (areset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge pclk) begin
      if (areset) begin
         tx_ready <= 1'b0;
         rx_valid <= 1'b0;
         rx_data <= '0;
         busy <= 1'b0;
         sclk <= CPOL;
         cs <= 1'b1;
         mosi <= 1'b0;
         cnt <= '0;
         ecnt <= '0;
         tx_sh <= '0;
         rx_sh <= '0;
      end else begin
         tx_ready <= state_nxt == IDLE;
         rx_valid <= done;
         cnt <= (state == IDLE || term) ? '0 : cnt + 16'd1;
         ecnt <= state != TRANSFER ? '0 : tog ? ecnt + 7'd1 : ecnt;
         sclk <= sclk ^ tog;
         if (accept) begin
            tx_sh <= tx_data;
            cs <= 1'b0;
            busy <= 1'b1;
            mosi <= CPHA ? 1'b0 : data_first;
         end else if (shift) begin
            tx_sh <= tx_nxt;
            mosi <= CPHA ? sh_first : nxt_first;
         end else if (done) begin
            cs <= 1'b1;
            busy <= 1'b0;
            mosi <= 1'b0;
            rx_data <= rx_sh;
         end
         if (sample) rx_sh <= MSB_FIRST ? {rx_sh[DATA_WIDTH-2:0], miso} : {miso, rx_sh[DATA_WIDTH-1:1]};
      end
   end
endmodule

// File: tb/tb_spi_master_controller.sv
// tb_spi_master_controller: four configurations of the SPI master against a behavioural slave
module tb_spi_master_controller;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   localparam bit [3:0] CPOL_V = 4'b0100, CPHA_V = 4'b0100, MSB_V = 4'b1101;
   localparam int CD_V [4] = '{2, 2, 2, 1};
   localparam int C2T_V [4] = '{1, 1, 1, 3};
   localparam int T2C_V [4] = '{1, 1, 1, 2};
   logic [3:0] tv = '0, mi = '0, tr, rv, bz, sc, csb, mo;
   logic [7:0] td [4] = '{default: '0};
   logic [7:0] rd [4];
   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_master_controller #(
         .DATA_WIDTH(8), .CLK_DIV(CD_V[g]), .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]),
         .MSB_FIRST(MSB_V[g]), .C2T_DELAY(C2T_V[g]), .T2C_DELAY(T2C_V[g])
      ) u_dut (
         .pclk(clk), .areset(rst), .tx_valid(tv[g]), .tx_ready(tr[g]), .tx_data(td[g]),
         .rx_valid(rv[g]), .rx_data(rd[g]), .busy(bz[g]), .sclk(sc[g]), .cs(csb[g]),
         .mosi(mo[g]), .miso(mi[g])
      );
   end
   typedef struct {
      logic [7:0] rx, mo;
      int csl, first, tail, ne, bad, gap;
      logic rv, bz;
   } frame_t;
   typedef struct {
      int d;
      logic [7:0] tx, sw;
      bit lp;
      logic [7:0] rx, mo;
      int csl, first, tail;
   } vec_t;
   frame_t q[$];
   int sel = 0, total = 0, pass = 0, rv_total = 0, edges = 0;
   bit lp = 1'b0;
   logic [7:0] sw = '0, coll = '0;
   logic pc = 1'b1, ps = 1'b0, pm = 1'b0;
   int k = 0, cs_low = 0, first = -1, tail = 0, bad = 0, gap = 0;
   // slave model: drives miso per CPHA, collects mosi at its own sample edge, records frame timing
   always @(negedge clk) begin
      logic c, s, m, pol, ph, ms, tgl, ld, tl;
      c = csb[sel]; s = sc[sel]; m = mo[sel];
      pol = CPOL_V[sel]; ph = CPHA_V[sel]; ms = MSB_V[sel];
      if (!c) begin
         if (pc) begin
            cs_low = 0; edges = 0; k = 0; coll = '0; first = -1; tail = 0; bad = 0;
            if (!ph && !lp) begin mi[sel] = sw[ms ? 7 : 0]; k = 1; end
         end
         cs_low++;
         tgl = s != ps; ld = tgl && s != pol; tl = tgl && s == pol;
         if (tgl) begin edges++; if (first < 0) first = cs_low - 1; tail = 0; end
         tail++;
         if (!pc && m != pm && !(ph ? ld : tl)) bad++;
         if (!bz[sel]) bad++;
         if (ph ? tl : ld) coll = {coll[6:0], m};
         if (!lp && (ph ? ld : tl) && k < 8) begin mi[sel] = sw[ms ? 7 - k : k]; k++; end
      end else if (!pc) begin
         q.push_back('{rd[sel], coll, cs_low, first, tail, edges, bad, gap, rv[sel], bz[sel]});
         gap = 1;
      end else gap++;
      if (rv[sel]) rv_total++;
      if (lp) mi[sel] = m;
      pc = c; ps = s; pm = m;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask
   task automatic send(input int d, input logic [7:0] w);
      int n = 0;
      td[d] = w; tv[d] = 1'b1;
      while (!tr[d] && n < 100) begin @(negedge clk); n++; end
      @(negedge clk); tv[d] = 1'b0;
      chk("send_wait", 32'(n < 100), 1);
   endtask
   task automatic wait_q(input int c);
      int n = 0;
      while (q.size() < c && n < 500) begin @(negedge clk); n++; end
      chk("frame_wait", 32'(n < 500), 1);
   endtask
   task automatic wait_cs(input int d, input logic lvl);
      int n = 0;
      while (csb[d] !== lvl && n < 500) begin @(negedge clk); n++; end
      chk("cs_wait", 32'(n < 500), 1);
   endtask
   initial begin
      vec_t v [5];
      frame_t f;
      int base, n;
      v[0] = '{0, 8'hA5, 8'h3C, 1'b0, 8'h3C, 8'hA5, 34, 3, 1};
      v[1] = '{1, 8'h01, 8'h80, 1'b0, 8'h80, 8'h80, 34, 3, 1};
      v[2] = '{2, 8'hF0, 8'h00, 1'b1, 8'hF0, 8'hF0, 34, 3, 1};
      v[3] = '{3, 8'hC3, 8'h96, 1'b0, 8'h96, 8'hC3, 21, 4, 2};
      v[4] = '{0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 34, 3, 1};
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(csb), 32'hF);
      chk("rst_sclk", 32'(sc), 32'(CPOL_V));
      chk("rst_ready", 32'(tr), 0);
      chk("rst_mosi", 32'(mo), 0);
      chk("rst_busy", 32'(bz), 0);
      chk("rst_rx_valid", 32'(rv), 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_rx_data%0d", i), 32'(rd[i]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(tr), 32'hF);
      for (int i = 0; i < 5; i++) begin
         sel = v[i].d; lp = v[i].lp; sw = v[i].sw; q.delete(); base = rv_total;
         @(negedge clk);
         send(v[i].d, v[i].tx);
         wait_q(1);
         repeat (3) @(negedge clk);
         if (q.size() > 0) begin
            f = q.pop_front();
            chk($sformatf("v%0d_rx_data", i), 32'(f.rx), 32'(v[i].rx));
            chk($sformatf("v%0d_mosi_bits", i), 32'(f.mo), 32'(v[i].mo));
            chk($sformatf("v%0d_cs_low", i), f.csl, v[i].csl);
            chk($sformatf("v%0d_first_edge", i), f.first, v[i].first);
            chk($sformatf("v%0d_tail", i), f.tail, v[i].tail);
            chk($sformatf("v%0d_sclk_toggles", i), f.ne, 16);
            chk($sformatf("v%0d_protocol_errors", i), f.bad, 0);
            chk($sformatf("v%0d_rx_valid_at_cs_rise", i), 32'(f.rv), 1);
            chk($sformatf("v%0d_busy_at_cs_rise", i), 32'(f.bz), 0);
         end
         chk($sformatf("v%0d_rx_valid_pulses", i), rv_total - base, 1);
      end
      // back-to-back frames with tx_valid held, then a word offered mid-frame
      sel = 0; lp = 1'b1; q.delete(); base = rv_total;
      @(negedge clk); td[0] = 8'h11; tv[0] = 1'b1;
      wait_cs(0, 1'b0);
      td[0] = 8'h22;
      chk("b2b_ready_while_busy", 32'(tr[0]), 0);
      wait_cs(0, 1'b1); wait_cs(0, 1'b0);
      tv[0] = 1'b0;
      repeat (10) @(negedge clk);
      td[0] = 8'h99; tv[0] = 1'b1;
      @(negedge clk);
      chk("midframe_ready", 32'(tr[0]), 0);
      chk("midframe_frames_done", q.size(), 1);
      wait_cs(0, 1'b1); wait_cs(0, 1'b0);
      tv[0] = 1'b0;
      wait_q(3);
      repeat (3) @(negedge clk);
      if (q.size() == 3) begin
         chk("b2b_rx0", 32'(q[0].rx), 32'h11);
         chk("b2b_mosi0", 32'(q[0].mo), 32'h11);
         chk("b2b_rx1", 32'(q[1].rx), 32'h22);
         chk("b2b_gap1", q[1].gap, 1);
         chk("b2b_rx2", 32'(q[2].rx), 32'h99);
         chk("b2b_gap2", q[2].gap, 1);
      end
      chk("b2b_rx_valid_pulses", rv_total - base, 3);
      // reset during bit 4 aborts the frame
      lp = 1'b0; sw = 8'h3C; q.delete();
      send(0, 8'hA5);
      wait_cs(0, 1'b0);
      @(negedge clk);
      n = 0;
      while (edges < 7 && n < 200) begin @(negedge clk); n++; end
      chk("abort_wait", 32'(n < 200), 1);
      base = rv_total; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_cs", 32'(csb[0]), 1);
      chk("abort_sclk", 32'(sc[0]), 0);
      chk("abort_busy", 32'(bz[0]), 0);
      chk("abort_mosi", 32'(mo[0]), 0);
      chk("abort_rx_data", 32'(rd[0]), 0);
      repeat (3) @(negedge clk);
      chk("abort_no_rx_valid", rv_total - base, 0);
      q.delete(); sw = 8'hC3; base = rv_total;
      send(0, 8'h5A);
      wait_q(1);
      repeat (3) @(negedge clk);
      if (q.size() > 0) begin
         f = q.pop_front();
         chk("post_abort_rx", 32'(f.rx), 32'hC3);
         chk("post_abort_mosi", 32'(f.mo), 32'h5A);
         chk("post_abort_cs_low", f.csl, 34);
      end
      chk("post_abort_rx_valid_pulses", rv_total - base, 1);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
